// File: rtl/lmac_reg_rd_arb.sv
// Round-robin arbiter sharing the single LMAC register-read port among NREQ requesters.
// Defining LMAC_REG_RD_TIMEOUT_EN adds a WAIT timeout that completes the read with err and all-ones data.
module lmac_reg_rd_arb #(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        err,
    output logic [DATA_W-1:0]      rd_data,
    output logic [ADDR_W-1:0]      host_addr_reg,
    output logic                   reg_rd_start,
    input  logic                   reg_rd_done_out,
    input  logic [DATA_W-1:0]      FMAC_REGDOUT
);

    localparam int PTR_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_param_chk
        $error("lmac_reg_rd_arb: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_win;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_rd_data;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_idx;
    logic                w_found;
    logic                w_to;
    logic                w_busy;
    logic [NREQ-1:0]     w_onehot;

    // Search starts at r_ptr and wraps; first requester found wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = PTR_W'((int'(r_ptr) + i) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = reg_rd_done_out ? S_RESP : S_WAIT;
            S_WAIT:  if (reg_rd_done_out || w_to) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_ptr     <= '0;
            r_win     <= '0;
            r_addr    <= '0;
            r_rd_data <= '0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_win  <= w_win;
                r_addr <= req_addr[w_win*ADDR_W +: ADDR_W];
            end
            // A completion in the same cycle as the timeout wins.
            if ((r_state == S_ISSUE || r_state == S_WAIT) && reg_rd_done_out) begin
                r_rd_data <= FMAC_REGDOUT;
            end else if (r_state == S_WAIT && w_to) begin
                r_rd_data <= '1;
            end
            if (r_state == S_RESP) begin
                r_ptr <= (r_win == PTR_W'(NREQ - 1)) ? '0 : r_win + 1'b1;
            end
        end
    end

`ifdef LMAC_REG_RD_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_to;

    assign w_to = (r_state == S_WAIT) && (r_cnt == 16'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            if (r_state == S_WAIT && !reg_rd_done_out && !w_to) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == S_ISSUE || r_state == S_WAIT) && reg_rd_done_out) begin
                r_to <= 1'b0;
            end else if (w_to) begin
                r_to <= 1'b1;
            end
        end
    end

    assign err = (r_state == S_RESP && r_to) ? w_onehot : '0;
`else
    assign w_to = 1'b0;
    assign err  = '0;
`endif

    assign w_busy        = (r_state != S_IDLE);
    assign w_onehot      = NREQ'(1) << r_win;
    assign gnt           = w_busy ? w_onehot : '0;
    assign done          = (r_state == S_RESP) ? w_onehot : '0;
    assign reg_rd_start  = (r_state == S_ISSUE);
    assign host_addr_reg = r_addr;
    assign rd_data       = r_rd_data;

endmodule

// File: tb/tb_lmac_reg_rd_arb.sv
// Directed testbench for lmac_reg_rd_arb; timeout scenarios run when LMAC_REG_RD_TIMEOUT_EN is defined.
module tb_lmac_reg_rd_arb;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   reset_;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [NREQ-1:0]        err;
    logic [DATA_W-1:0]      rd_data;
    logic [ADDR_W-1:0]      host_addr_reg;
    logic                   reg_rd_start;
    logic                   reg_rd_done_out;
    logic [DATA_W-1:0]      FMAC_REGDOUT;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lmac_reg_rd_arb #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_CYCLES(8)
    ) dut (
        .clk(clk), .reset_(reset_), .req(req), .req_addr(req_addr),
        .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
        .host_addr_reg(host_addr_reg), .reg_rd_start(reg_rd_start),
        .reg_rd_done_out(reg_rd_done_out), .FMAC_REGDOUT(FMAC_REGDOUT)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset_ = 1'b0; req = '0; reg_rd_done_out = 1'b0; FMAC_REGDOUT = '0;
        tick; tick;
        reset_ = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        reset_ = 1'b0; req = 4'b0001; reg_rd_done_out = 1'b0; FMAC_REGDOUT = '0;
        req_addr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        tick; tick;
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b want 0000", done); end
        n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b want 0000", err); end
        n_tests++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_tests++; if (host_addr_reg !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", host_addr_reg); end
        n_tests++; if (reg_rd_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", reg_rd_start); end
        req = '0;
        reset_ = 1'b1;
        tick;
    endtask

    task automatic test_single;
        req_addr = {16'h4444, 16'h3333, 16'h2222, 16'h0010};
        req = 4'b0001;
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_idle_gnt: got %b want 0000", gnt); end
        tick;
        n_tests++; if (reg_rd_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", reg_rd_start); end
        n_tests++; if (host_addr_reg !== 16'h0010) begin n_fail++; $display("FAIL single_addr: got %h want 0010", host_addr_reg); end
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_early_done: got %b want 0000", done); end
        reg_rd_done_out = 1'b1; FMAC_REGDOUT = 32'h00000808;
        req_addr[15:0] = 16'hBEEF;
        tick;
        n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", done); end
        n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL single_err: got %b want 0000", err); end
        n_tests++; if (rd_data !== 32'h00000808) begin n_fail++; $display("FAIL single_rd_data: got %h want 00000808", rd_data); end
        n_tests++; if (reg_rd_start !== 1'b0) begin n_fail++; $display("FAIL single_start_once: got %b want 0", reg_rd_start); end
        n_tests++; if (host_addr_reg !== 16'h0010) begin n_fail++; $display("FAIL single_addr_hold: got %h want 0010", host_addr_reg); end
        reg_rd_done_out = 1'b1; FMAC_REGDOUT = 32'hDEAD0000;
        req = 4'b0000;
        tick;
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_drop: got %b want 0000", gnt); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0000", done); end
        n_tests++; if (rd_data !== 32'h00000808) begin n_fail++; $display("FAIL resp_ignore: got %h want 00000808", rd_data); end
        FMAC_REGDOUT = 32'hDEAD0001;
        tick;
        n_tests++; if (rd_data !== 32'h00000808) begin n_fail++; $display("FAIL idle_ignore: got %h want 00000808", rd_data); end
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt: got %b want 0000", gnt); end
        reg_rd_done_out = 1'b0;
        tick;
    endtask

    task automatic test_fairness;
        logic [15:0] addrs [4];
        logic [3:0]  e;
        addrs = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        apply_reset;
        req_addr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = 4'(1 << (k % 4));
            tick;
            n_tests++; if (gnt !== e) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, e); end
            n_tests++; if (host_addr_reg !== addrs[k % 4]) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", k, host_addr_reg, addrs[k % 4]); end
            tick;
            tick;
            reg_rd_done_out = 1'b1; FMAC_REGDOUT = 32'hA0000000 + 32'(k);
            tick;
            reg_rd_done_out = 1'b0;
            n_tests++; if (done !== e) begin n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", k, done, e); end
            n_tests++; if (rd_data !== 32'hA0000000 + 32'(k)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", k, rd_data, 32'hA0000000 + 32'(k)); end
            tick;
            n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_gap[%0d]: got %b want 0000", k, gnt); end
        end
        req = 4'b0000;
        tick;
    endtask

`ifdef LMAC_REG_RD_TIMEOUT_EN
    task automatic test_timeout;
        apply_reset;
        req = 4'b0100;
        tick;
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL to_gnt: got %b want 0100", gnt); end
        for (int i = 0; i < 8; i++) tick;
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL to_early: got %b want 0000", done); end
        tick;
        n_tests++; if (done !== 4'b0100) begin n_fail++; $display("FAIL to_done: got %b want 0100", done); end
        n_tests++; if (err !== 4'b0100) begin n_fail++; $display("FAIL to_err: got %b want 0100", err); end
        n_tests++; if (rd_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL to_data: got %h want ffffffff", rd_data); end
        req = 4'b0000;
        tick;
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL to_idle_gnt: got %b want 0000", gnt); end
        n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL to_err_pulse: got %b want 0000", err); end
        tick;
    endtask

    task automatic test_timeout_tie;
        req = 4'b0100;
        tick;
        for (int i = 0; i < 8; i++) tick;
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL tie_early: got %b want 0000", done); end
        reg_rd_done_out = 1'b1; FMAC_REGDOUT = 32'hCAFE0001;
        tick;
        reg_rd_done_out = 1'b0;
        n_tests++; if (done !== 4'b0100) begin n_fail++; $display("FAIL tie_done: got %b want 0100", done); end
        n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL tie_err: got %b want 0000", err); end
        n_tests++; if (rd_data !== 32'hCAFE0001) begin n_fail++; $display("FAIL tie_data: got %h want cafe0001", rd_data); end
        req = 4'b0000;
        tick;
    endtask
`else
    task automatic test_no_timeout;
        apply_reset;
        req = 4'b0100;
        tick;
        for (int i = 0; i < 20; i++) tick;
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL wait_done: got %b want 0000", done); end
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wait_gnt: got %b want 0100", gnt); end
        reg_rd_done_out = 1'b1; FMAC_REGDOUT = 32'hCAFE0002;
        tick;
        reg_rd_done_out = 1'b0;
        n_tests++; if (done !== 4'b0100) begin n_fail++; $display("FAIL wait_resp_done: got %b want 0100", done); end
        n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL wait_err: got %b want 0000", err); end
        n_tests++; if (rd_data !== 32'hCAFE0002) begin n_fail++; $display("FAIL wait_data: got %h want cafe0002", rd_data); end
        req = 4'b0000;
        tick;
    endtask
`endif

    task automatic test_dropped_req;
        apply_reset;
        req = 4'b0010;
        tick;
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL drop_gnt: got %b want 0010", gnt); end
        tick;
        req = 4'b1101;
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL drop_gnt_hold: got %b want 0010", gnt); end
        tick;
        reg_rd_done_out = 1'b1; FMAC_REGDOUT = 32'h00001111;
        tick;
        reg_rd_done_out = 1'b0;
        n_tests++; if (done !== 4'b0010) begin n_fail++; $display("FAIL drop_done: got %b want 0010", done); end
        n_tests++; if (rd_data !== 32'h00001111) begin n_fail++; $display("FAIL drop_data: got %h want 00001111", rd_data); end
        tick;
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL drop_idle: got %b want 0000", gnt); end
        tick;
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL drop_next_gnt: got %b want 0100", gnt); end
        n_tests++; if (host_addr_reg !== 16'h3333) begin n_fail++; $display("FAIL drop_next_addr: got %h want 3333", host_addr_reg); end
        reg_rd_done_out = 1'b1; FMAC_REGDOUT = 32'h00002222;
        tick;
        reg_rd_done_out = 1'b0;
        n_tests++; if (done !== 4'b0100) begin n_fail++; $display("FAIL drop_next_done: got %b want 0100", done); end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_mid_reset;
        req = 4'b0001;
        tick;
        tick;
        reset_ = 1'b0;
        #1;
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mrst_gnt: got %b want 0000", gnt); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL mrst_done: got %b want 0000", done); end
        n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL mrst_err: got %b want 0000", err); end
        n_tests++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL mrst_data: got %h want 0", rd_data); end
        n_tests++; if (host_addr_reg !== 16'h0) begin n_fail++; $display("FAIL mrst_addr: got %h want 0", host_addr_reg); end
        n_tests++; if (reg_rd_start !== 1'b0) begin n_fail++; $display("FAIL mrst_start: got %b want 0", reg_rd_start); end
        req = 4'b0000;
        reg_rd_done_out = 1'b1; FMAC_REGDOUT = 32'h55555555;
        tick;
        reg_rd_done_out = 1'b0;
        tick;
        reset_ = 1'b1;
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL mrst_no_done: got %b want 0000", done); end
        tick;
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL mrst_no_done_after: got %b want 0000", done); end
        req = 4'b1000;
        tick;
        n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL mrst_regnt: got %b want 1000", gnt); end
        reg_rd_done_out = 1'b1; FMAC_REGDOUT = 32'h00003333;
        tick;
        reg_rd_done_out = 1'b0;
        n_tests++; if (done !== 4'b1000) begin n_fail++; $display("FAIL mrst_redone: got %b want 1000", done); end
        req = 4'b0000;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_single;
        test_fairness;
`ifdef LMAC_REG_RD_TIMEOUT_EN
        test_timeout;
        test_timeout_tie;
`else
        test_no_timeout;
`endif
        test_dropped_req;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
